// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: operand width, FSM encoding and
// the round-robin pick helper.
package adder_arbiter_pkg;

    localparam int unsigned OPW     = 32;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Round-robin search: scan from ptr upwards, wrapping at nreq-1 back to 0,
    // and return the first requester whose valid bit is set.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int unsigned        nreq);
        pick_t       p;
        int unsigned cand;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                cand = 32'(ptr) + k;
                if (cand >= nreq) begin
                    cand = cand - nreq;
                end
                if (!p.found && valid[3'(cand)]) begin
                    p.found = 1'b1;
                    p.idx   = 3'(cand);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/adder_arbiter_rca.sv
// 32-bit ripple-carry adder; exposes the carry into the MSB as well as the
// carry out so the caller can derive signed overflow.
module adder_arbiter_rca
    import adder_arbiter_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           cin,
    output logic [OPW-1:0] sum,
    output logic           c31,
    output logic           cout
);

    logic [OPW:0] carry;

    // Bit-serial carry chain, one full adder per bit.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < OPW; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c31  = carry[OPW-1];
    assign cout = carry[OPW];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NREQ requesters.
// An operation is accepted, computed in the following cycle and then held
// on the result port until the consumer takes it.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    input  logic [NREQ-1:0]     req_sub,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [OPW-1:0]      res_sum,
    output logic                res_cout,
    output logic                res_ovf,
    output logic [IDW-1:0]      res_id
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [OPW-1:0]   op_a_q, op_a_d;
    logic [OPW-1:0]   op_b_q, op_b_d;
    logic             op_sub_q, op_sub_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    logic             res_valid_q, res_valid_d;
    logic [OPW-1:0]   res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             res_ovf_q, res_ovf_d;
    logic [IDW-1:0]   res_id_q, res_id_d;

    logic [MAX_REQ-1:0] valid_pad;
    pick_t              pick;
    logic               can_grant;
    logic               grant_en;
    logic [IDW-1:0]     gnt_id;
    logic [OPW-1:0]     sel_a;
    logic [OPW-1:0]     sel_b;
    logic               sel_sub;

    logic [OPW-1:0]     add_b;
    logic [OPW-1:0]     add_sum;
    logic               add_c31;
    logic               add_cout;

    // Arbitration: pick from the pointer; a grant is only possible when the
    // result slot is free (IDLE) or being drained this cycle (HOLD + res_ready).
    always_comb begin
        valid_pad             = '0;
        valid_pad[NREQ-1:0]   = req_valid;
        pick                  = rr_pick(valid_pad, 3'(ptr_q), NREQ);
        gnt_id                = IDW'(pick.idx);
        can_grant             = rst_n && ((state_q == ST_IDLE) ||
                                          ((state_q == ST_HOLD) && res_ready));
        grant_en              = can_grant && pick.found;
        req_ready             = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_en && (pick.idx == 3'(i));
        end
    end

    // Operand mux for the requester chosen by the arbiter.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick.idx == 3'(i)) begin
                sel_a   = req_a[i*OPW +: OPW];
                sel_b   = req_b[i*OPW +: OPW];
                sel_sub = req_sub[i];
            end
        end
    end

    // Subtraction is A + ~B + 1 through the same adder.
    assign add_b = op_b_q ^ {OPW{op_sub_q}};

    adder_arbiter_rca u_rca (
        .a    (op_a_q),
        .b    (add_b),
        .cin  (op_sub_q),
        .sum  (add_sum),
        .c31  (add_c31),
        .cout (add_cout)
    );

    // Next-state and datapath updates; a grant always launches CALC, so the
    // operand capture is shared by the IDLE and HOLD paths.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sub_d    = op_sub_q;
        op_id_d     = op_id_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        res_id_d    = res_id_q;

        if (grant_en) begin
            op_a_d   = sel_a;
            op_b_d   = sel_b;
            op_sub_d = sel_sub;
            op_id_d  = gnt_id;
            if (pick.idx == 3'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + IDW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                res_sum_d   = add_sum;
                res_cout_d  = add_cout;
                res_ovf_d   = add_c31 ^ add_cout;
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = grant_en ? ST_CALC : ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sub_q    <= 1'b0;
            op_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sub_q    <= op_sub_d;
            op_id_q     <= op_id_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
            res_id_q    <= res_id_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_id    = res_id_q;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters (2..8).
REQ-002 Parameter IDW, default 2: requester-id width, equal to clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation pending.
REQ-006 req_ready  output  NREQ  per-requester operand accept; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*32  signed operand A per requester; requester i occupies bits [32i+31:32i].
REQ-008 req_b  input  NREQ*32  signed operand B per requester, same packing.
REQ-009 req_sub  input  NREQ  1 = A-B, 0 = A+B.
REQ-010 res_valid  output  1  result held.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_sum  output  32  sum or difference.
REQ-013 res_cout  output  1  carry out of bit 31.
REQ-014 res_ovf  output  1  signed overflow, carry(31) XOR carry(32).
REQ-015 res_id  output  IDW  index of the requester that owns the result.

Function
REQ-016 The block SHALL share one 32-bit ripple-carry adder instance among NREQ requesters.
REQ-017 FSM states SHALL be IDLE, CALC and HOLD.
REQ-018 In IDLE, if any req_valid is high, the block SHALL grant exactly one requester, assert its req_ready in that cycle, latch its A, B, sub and id, and move to CALC; otherwise it SHALL stay in IDLE.
REQ-019 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high; req_ready SHALL depend on state, the RR pointer and req_valid, never on operand data.
REQ-020 In CALC, the adder SHALL be driven with A, B XOR {32{sub}} and Cin = sub; sum, cout and ovf SHALL be registered; the FSM SHALL move to HOLD with res_valid = 1.
REQ-021 In HOLD, outputs SHALL remain stable until res_valid and res_ready are both high.
REQ-022 In HOLD, when res_ready = 1: if any req_valid is high, the block SHALL grant and latch a new requester in that cycle and move to CALC; otherwise it SHALL move to IDLE.
REQ-023 req_ready SHALL be 0 in CALC, and 0 in HOLD while res_ready = 0.
REQ-024 Latency SHALL be 2 cycles from an accept edge to res_valid; peak throughput SHALL be one result per 2 cycles.
REQ-025 Arbitration SHALL be round-robin: the search starts at the pointer and wraps from NREQ-1 to 0; after each grant, the pointer becomes (grant+1) mod NREQ.
REQ-026 Under continuous requests from all requesters, no requester SHALL wait more than NREQ-1 grants.
REQ-027 Requesters SHALL hold valid and operands stable until accepted; a withdrawn req_valid before grant SHALL be ignored without error.
REQ-028 Arithmetic SHALL wrap modulo 2^32; res_ovf is informational and SHALL NOT alter res_sum.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously enter IDLE and clear res_valid, res_sum, res_cout, res_ovf, res_id, the latched operands and the RR pointer to 0.
REQ-030 req_ready SHALL be 0 while rst_n is low.
REQ-031 A reset in CALC or HOLD SHALL discard the operation with no result emitted.
REQ-032 After reset release, the first grant SHALL use pointer 0.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the operand width constant (32).
REQ-034 The existing 32-bit ripple-carry adder module SHALL be instantiated once as the sole sub-module; a round-robin pick function may reside in the package.

Verification
REQ-035 Single request: req0 issues A=5, B=7, add -> req_ready[0] in the same cycle; two cycles later res_valid=1, res_sum=12, res_cout=0, res_ovf=0, res_id=0.
REQ-036 Subtract overflow: A=0x80000000, B=1, sub=1 -> res_sum=0x7FFFFFFF, res_ovf=1, res_cout=1.
REQ-037 Add overflow: A=0x7FFFFFFF, B=1, add -> res_sum=0x80000000, res_ovf=1, res_cout=0.
REQ-038 Fairness: all 4 requesters valid continuously with res_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles.
REQ-039 Backpressure: res_ready=0 for 5 cycles while in HOLD -> outputs stable and req_ready all 0; when res_ready rises with req2 valid -> req2 is granted in that same cycle.
REQ-040 Reset in CALC: rst_n asserted mid-CALC -> res_valid=0 and no result appears; after release, the first grant goes to the lowest-index valid requester from pointer 0.
